// File: rtl/hall_speed_meter.sv
// Hall-sensor speed meter: debounces the 3-bit hall bus, counts legal steps per
// gate window and publishes scaled, saturated rev/speed samples with a strobe.
module hall_speed_meter #(
  parameter int unsigned GATE_CYCLE   = 10_000_000,
  parameter int unsigned FILTER_CYCLE = 16,
  parameter int unsigned REV_PER_EDGE = 25,
  parameter int unsigned SPEED_MUL    = 3,
  parameter int unsigned SPEED_SHIFT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  hall_in,
  output logic [13:0] engine_rev,
  output logic [8:0]  vehicle_speed,
  output logic        direction,
  output logic        hall_fault,
  output logic        update
);

  localparam int GW  = (GATE_CYCLE > 1) ? $clog2(GATE_CYCLE) : 1;
  localparam int FW  = $clog2(FILTER_CYCLE + 1);
  localparam int RPW = (REV_PER_EDGE > 0) ? $clog2(REV_PER_EDGE + 1) : 1;
  localparam int SMW = (SPEED_MUL > 0) ? $clog2(SPEED_MUL + 1) : 1;
  localparam int RW  = 16 + RPW;
  localparam int SW  = 16 + SMW;

  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLE - 1);
  localparam logic [FW-1:0] FILT_N    = FW'(FILTER_CYCLE);
  localparam logic [2:0]    UNKNOWN   = 3'b000;

  // Forward rotation order: 001 -> 011 -> 010 -> 110 -> 100 -> 101 -> 001
  function automatic logic [2:0] fwd_next(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      3'b001:  n = 3'b011;
      3'b011:  n = 3'b010;
      3'b010:  n = 3'b110;
      3'b110:  n = 3'b100;
      3'b100:  n = 3'b101;
      3'b101:  n = 3'b001;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  logic [2:0]    s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, code_q, code_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [GW-1:0] gate_q, gate_d;
  logic [15:0]   edge_q, edge_d, snap_q, snap_d, edge_next;
  logic          flag_q, flag_d, dir_last_q, dir_last_d;
  logic          fault_snap_q, fault_snap_d, dir_snap_q, dir_snap_d;
  logic          pub_q, pub_d;
  logic [13:0]   rev_q, rev_d;
  logic [8:0]    spd_q, spd_d;
  logic          dir_q, dir_d, fault_q, fault_d, update_q, update_d;

  logic          accept, fault_now, cnt_edge;
  logic [RW-1:0] rev_prod;
  logic [SW-1:0] spd_prod, spd_shr;
  logic [13:0]   rev_sat;
  logic [8:0]    spd_sat;

  always_comb begin
    rev_prod = RW'(snap_q) * RW'(REV_PER_EDGE);
    spd_prod = SW'(snap_q) * SW'(SPEED_MUL);
    spd_shr  = spd_prod >> SPEED_SHIFT;
    rev_sat  = (rev_prod > RW'(16383)) ? 14'h3FFF : rev_prod[13:0];
    spd_sat  = (spd_shr > SW'(511)) ? 9'h1FF : spd_shr[8:0];
  end

  always_comb begin
    s1_d         = hall_in;
    s2_d         = s1_q;
    cand_d       = s2_q;
    code_d       = code_q;
    filt_d       = filt_q;
    gate_d       = gate_q;
    edge_d       = edge_q;
    snap_d       = snap_q;
    flag_d       = flag_q;
    dir_last_d   = dir_last_q;
    fault_snap_d = fault_snap_q;
    dir_snap_d   = dir_snap_q;
    pub_d        = 1'b0;
    rev_d        = rev_q;
    spd_d        = spd_q;
    dir_d        = dir_q;
    fault_d      = fault_q;
    update_d     = 1'b0;
    accept       = 1'b0;
    fault_now    = 1'b0;
    cnt_edge     = 1'b0;

    // filt counts the current run of an unchanged sample that differs from code_q
    if (s2_q == code_q) begin
      filt_d = '0;
    end else begin
      if (s2_q != cand_q)
        filt_d = FW'(1);
      else if (filt_q != FILT_N)
        filt_d = filt_q + FW'(1);
      accept = (filt_d == FILT_N);
    end

    if (accept) begin
      if (s2_q == 3'b000 || s2_q == 3'b111) begin
        fault_now = 1'b1;
        code_d    = UNKNOWN;
      end else if (code_q == UNKNOWN) begin
        code_d = s2_q;
      end else if (s2_q == fwd_next(code_q)) begin
        cnt_edge   = 1'b1;
        dir_last_d = 1'b1;
        code_d     = s2_q;
      end else if (fwd_next(s2_q) == code_q) begin
        cnt_edge   = 1'b1;
        dir_last_d = 1'b0;
        code_d     = s2_q;
      end else begin
        fault_now = 1'b1;
        code_d    = s2_q;
      end
    end

    edge_next = (cnt_edge && edge_q != 16'hFFFF) ? edge_q + 16'd1 : edge_q;

    if (gate_q == GATE_LAST) begin
      gate_d       = '0;
      snap_d       = edge_next;
      fault_snap_d = flag_q | fault_now;
      dir_snap_d   = dir_last_d;
      edge_d       = '0;
      flag_d       = 1'b0;
      pub_d        = 1'b1;
    end else begin
      gate_d = gate_q + GW'(1);
      edge_d = edge_next;
      flag_d = flag_q | fault_now;
    end

    if (pub_q) begin
      rev_d    = rev_sat;
      spd_d    = spd_sat;
      fault_d  = fault_snap_q;
      if (snap_q != 16'd0)
        dir_d = dir_snap_q;
      update_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      cand_q       <= '0;
      code_q       <= UNKNOWN;
      filt_q       <= '0;
      gate_q       <= '0;
      edge_q       <= '0;
      snap_q       <= '0;
      flag_q       <= 1'b0;
      dir_last_q   <= 1'b0;
      fault_snap_q <= 1'b0;
      dir_snap_q   <= 1'b0;
      pub_q        <= 1'b0;
      rev_q        <= '0;
      spd_q        <= '0;
      dir_q        <= 1'b0;
      fault_q      <= 1'b0;
      update_q     <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      cand_q       <= cand_d;
      code_q       <= code_d;
      filt_q       <= filt_d;
      gate_q       <= gate_d;
      edge_q       <= edge_d;
      snap_q       <= snap_d;
      flag_q       <= flag_d;
      dir_last_q   <= dir_last_d;
      fault_snap_q <= fault_snap_d;
      dir_snap_q   <= dir_snap_d;
      pub_q        <= pub_d;
      rev_q        <= rev_d;
      spd_q        <= spd_d;
      dir_q        <= dir_d;
      fault_q      <= fault_d;
      update_q     <= update_d;
    end
  end

  assign engine_rev    = rev_q;
  assign vehicle_speed = spd_q;
  assign direction     = dir_q;
  assign hall_fault    = fault_q;
  assign update        = update_q;

endmodule

// File: tb/tb_hall_speed_meter.sv
// Bench for hall_speed_meter: directed scenarios plus a random window, checked
// every cycle against a window-level behavioural model.
module tb_hall_speed_meter;

  localparam int GATE  = 10000;
  localparam int FILT  = 4;
  localparam int REV   = 25;
  localparam int SMUL  = 3;
  localparam int SSHR  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hall_in;
  logic [13:0] engine_rev;
  logic [8:0]  vehicle_speed;
  logic        direction, hall_fault, update;

  hall_speed_meter #(
    .GATE_CYCLE(GATE), .FILTER_CYCLE(FILT), .REV_PER_EDGE(REV),
    .SPEED_MUL(SMUL), .SPEED_SHIFT(SSHR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hall_in(hall_in),
    .engine_rev(engine_rev), .vehicle_speed(vehicle_speed),
    .direction(direction), .hall_fault(hall_fault), .update(update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int SEQ[6] = '{1, 3, 2, 6, 4, 5};

  function automatic int seq_idx(input logic [2:0] c);
    for (int i = 0; i < 6; i++)
      if (SEQ[i] == int'(c)) return i;
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int due;
    int rev;
    int spd;
    int cnt;
    bit fault;
    bit dir;
  } pub_t;

  pub_t        pend[$];
  pub_t        p;
  logic [2:0]  hist[$];
  logic [2:0]  d1, d2, mx, mcode;
  int          mc, medges, pi, xi;
  bit          mflag, mdirlast, stable, model_live = 0;
  logic [13:0] m_rev;
  logic [8:0]  m_spd;
  logic        m_dir, m_fault, m_upd;

  always @(posedge clk) begin
    model_live = 1;
    if (!rst_n) begin
      mc = 0; d1 = 0; d2 = 0; mcode = 0; medges = 0; mflag = 0; mdirlast = 0;
      hist.delete(); pend.delete();
      m_rev = 0; m_spd = 0; m_dir = 0; m_fault = 0; m_upd = 0;
    end else begin
      mx = d2; d2 = d1; d1 = hall_in;
      m_upd = 0;
      if (pend.size() > 0 && pend[0].due == mc) begin
        m_rev   = 14'(pend[0].rev);
        m_spd   = 9'(pend[0].spd);
        m_fault = pend[0].fault;
        if (pend[0].cnt != 0) m_dir = pend[0].dir;
        m_upd = 1;
        pend.delete(0);
      end
      hist.push_back(mx);
      if (hist.size() > FILT) hist.delete(0);
      stable = (hist.size() == FILT);
      foreach (hist[i]) if (hist[i] != mx) stable = 0;
      if (stable && mx != mcode) begin
        pi = seq_idx(mcode);
        xi = seq_idx(mx);
        if (xi < 0) begin
          mflag = 1; mcode = 0;
        end else if (pi < 0) begin
          mcode = mx;
        end else if (xi == (pi + 1) % 6) begin
          if (medges < 65535) medges++;
          mdirlast = 1; mcode = mx;
        end else if (xi == (pi + 5) % 6) begin
          if (medges < 65535) medges++;
          mdirlast = 0; mcode = mx;
        end else begin
          mflag = 1; mcode = mx;
        end
      end
      if (mc % GATE == GATE - 1) begin
        p.due   = mc + 1;
        p.cnt   = medges;
        p.rev   = (medges * REV > 16383) ? 16383 : medges * REV;
        p.spd   = (((medges * SMUL) >> SSHR) > 511) ? 511 : ((medges * SMUL) >> SSHR);
        p.fault = mflag;
        p.dir   = mdirlast;
        pend.push_back(p);
        medges = 0; mflag = 0;
      end
      mc++;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checks++;
      if (engine_rev !== m_rev || vehicle_speed !== m_spd || direction !== m_dir ||
          hall_fault !== m_fault || update !== m_upd) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t dut rev=%0d spd=%0d dir=%b flt=%b upd=%b model rev=%0d spd=%0d dir=%b flt=%b upd=%b",
                 $time, engine_rev, vehicle_speed, direction, hall_fault, update,
                 m_rev, m_spd, m_dir, m_fault, m_upd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [2:0] cur_code;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input int hold);
    hall_in  = c;
    cur_code = c;
    repeat (hold) @(negedge clk);
  endtask

  task automatic step_dir(input bit fwd, input int hold);
    int i;
    i = seq_idx(cur_code);
    drive(3'(SEQ[fwd ? (i + 1) % 6 : (i + 5) % 6]), hold);
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while (mc % GATE != ph && k < 2 * GATE) begin
      @(negedge clk);
      k++;
    end
  endtask

  // A negative expectation skips that field.
  task automatic check_pub(input string nm, input int rev, input int spd, input int dir, input int flt);
    int k = 0;
    while (update !== 1'b1 && k < 2 * GATE) begin
      @(negedge clk);
      k++;
    end
    if (update !== 1'b1) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      if (rev >= 0) chk({nm, "_rev"}, int'(engine_rev), rev);
      if (spd >= 0) chk({nm, "_spd"}, int'(vehicle_speed), spd);
      if (dir >= 0) chk({nm, "_dir"}, int'(direction), dir);
      if (flt >= 0) chk({nm, "_fault"}, int'(hall_fault), flt);
    end
    @(negedge clk);
  endtask

  int n, k;
  logic [2:0] g;

  initial begin
    rst_n = 1'b0;
    hall_in = 3'b000;
    cur_code = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_rev", int'(engine_rev), 0);
    chk("reset_upd", int'(update), 0);
    rst_n = 1'b1;

    // forward, 12 counted edges
    drive(3'b001, 14);
    repeat (12) step_dir(1, 14);
    check_pub("fwd12", 300, 9, 1, 0);

    // glitches of 2 and 3 cycles are rejected; a 4-cycle hold counts
    wait_phase(20);
    drive(3'b011, 2); drive(3'b001, 14);
    drive(3'b011, 3); drive(3'b001, 14);
    drive(3'b011, 4); drive(3'b001, 14);
    check_pub("glitch", 50, 1, 0, 0);

    // 700 edges saturate both outputs
    wait_phase(20);
    repeat (700) step_dir(1, 14);
    check_pub("sat700", 16383, 511, 1, 0);

    // reverse, 8 edges
    wait_phase(20);
    repeat (8) step_dir(0, 14);
    check_pub("rev8", 200, 6, 0, 0);

    // illegal 111 held mid-window; the following code only reloads
    wait_phase(20);
    repeat (2) step_dir(1, 14);
    drive(3'b111, 10);
    drive(3'b101, 14);
    check_pub("illegal", 50, 1, 1, 1);

    // random clean window with short glitches and mixed direction
    wait_phase(20);
    n = $urandom_range(40, 200);
    for (int s = 0; s < n; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        g = 3'($urandom_range(0, 7));
        if (g != cur_code) begin
          hall_in = g;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          hall_in = cur_code;
          @(negedge clk);
        end
      end
      step_dir(1'($urandom_range(0, 1)), $urandom_range(14, 24));
    end
    check_pub("random", -1, -1, -1, 0);

    // one-cycle reset mid-window
    wait_phase(5000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rev", int'(engine_rev), 0);
    chk("rst_spd", int'(vehicle_speed), 0);
    chk("rst_dir", int'(direction), 0);
    chk("rst_fault", int'(hall_fault), 0);
    chk("rst_upd", int'(update), 0);
    rst_n = 1'b1;
    k = 0;
    while (update !== 1'b1 && k < GATE + 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_latency", k, GATE + 1);
    chk("rst_win_rev", int'(engine_rev), 0);
    chk("rst_win_fault", int'(hall_fault), 0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
